piso_serializer: RTL and testbench

Parametrised parallel-in/serial-out serializer for the MRAM readout path. It takes WIDTH-bit words from the MRAM interface over a valid/ready handshake and buffers one word in a pending register, so a second word can be queued while the first is shifting out. Words go out bit-serially, MSB- or LSB-first, with a programmable number of clock cycles per bit. Framing strobes and a per-word done pulse are provided to the downstream link and the controller FSM.

---
 rtl/piso_pkg.sv | 23 ++
 rtl/piso_pending_buf.sv | 55 +++++
 rtl/piso_serializer.sv | 127 ++++++++++++
 tb/tb_piso_serializer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types, reset values and width helper for the PISO serializer.
package piso_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic RST_SDATA       = 1'b0;
  localparam logic RST_SFRAME      = 1'b0;
  localparam logic RST_WORD_START  = 1'b0;
  localparam logic RST_DONE        = 1'b0;
  localparam logic RST_BUSY        = 1'b0;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    if (n <= 1) r = 1;
    else        r = $clog2(n);
    return r;
  endfunction

endpackage

// File: rtl/piso_pending_buf.sv
// Single-entry holding register on the input handshake; bypasses straight to the
// shifter when the shifter can take a word in the same cycle.
module piso_pending_buf
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             load_ok,
  output logic             word_avail,
  output logic [WIDTH-1:0] word_data,
  output logic             pend_valid_next
);

  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             transfer;

  assign s_ready    = en & rst_n & ~pend_valid_q;
  assign transfer   = s_valid & s_ready;
  assign word_avail = pend_valid_q | transfer;
  // Pending word has priority; a transfer is impossible while it is held.
  assign word_data  = pend_valid_q ? pend_q : s_data;

  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (en) begin
      if (pend_valid_q && load_ok) begin
        pend_valid_d = 1'b0;
      end else if (transfer && !load_ok) begin
        pend_d       = s_data;
        pend_valid_d = 1'b1;
      end
    end
  end

  assign pend_valid_next = pend_valid_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with one-word pending buffer, programmable
// bit period, and registered framing/done strobes.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter int unsigned BIT_PERIOD = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             sdata,
  output logic             sframe,
  output logic             sword_start,
  output logic             done,
  output logic             busy
);

  localparam int unsigned BW = clog2_min1(WIDTH);
  localparam int unsigned PW = clog2_min1(BIT_PERIOD);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(BIT_PERIOD - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]    per_cnt_q, per_cnt_d;
  logic             sdata_q, sdata_d;
  logic             sframe_q, sframe_d;
  logic             sword_start_q, sword_start_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             word_end, load_ok, load;
  logic             word_avail, pend_valid_next;
  logic [WIDTH-1:0] word_data;

  assign word_end = (state_q == ST_SHIFT) && (bit_cnt_q == BIT_LAST) && (per_cnt_q == PER_LAST);
  assign load_ok  = (state_q == ST_IDLE) || word_end;
  assign load     = en && load_ok && word_avail;

  piso_pending_buf #(
    .WIDTH (WIDTH)
  ) u_pending_buf (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .load_ok         (load_ok),
    .word_avail      (word_avail),
    .word_data       (word_data),
    .pend_valid_next (pend_valid_next)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    per_cnt_d = per_cnt_q;
    if (load) begin
      state_d   = ST_SHIFT;
      shreg_d   = word_data;
      bit_cnt_d = '0;
      per_cnt_d = '0;
    end else if (word_end) begin
      state_d   = ST_IDLE;
      shreg_d   = '0;
      bit_cnt_d = '0;
      per_cnt_d = '0;
    end else if (state_q == ST_SHIFT) begin
      if (per_cnt_q == PER_LAST) begin
        per_cnt_d = '0;
        bit_cnt_d = bit_cnt_q + 1'b1;
        shreg_d   = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
      end else begin
        per_cnt_d = per_cnt_q + 1'b1;
      end
    end
  end

  // Outputs are computed from next state so they are registered yet aligned with it.
  always_comb begin
    sframe_d      = (state_d == ST_SHIFT);
    sdata_d       = sframe_d ? (LSB_FIRST ? shreg_d[0] : shreg_d[WIDTH-1]) : RST_SDATA;
    sword_start_d = load;
    done_d        = sframe_d && (bit_cnt_d == BIT_LAST) && (per_cnt_d == PER_LAST);
    busy_d        = sframe_d || pend_valid_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      per_cnt_q     <= '0;
      sdata_q       <= RST_SDATA;
      sframe_q      <= RST_SFRAME;
      sword_start_q <= RST_WORD_START;
      done_q        <= RST_DONE;
      busy_q        <= RST_BUSY;
    end else if (en) begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      per_cnt_q     <= per_cnt_d;
      sdata_q       <= sdata_d;
      sframe_q      <= sframe_d;
      sword_start_q <= sword_start_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  assign sdata       = sdata_q;
  assign sframe      = sframe_q;
  assign busy        = busy_q;
  // Held strobes reappear when en returns, so a stalled word still gets its pulse.
  assign sword_start = sword_start_q & en;
  assign done        = done_q & en;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two configurations checked every cycle against a
// word/cycle-index reference model, plus directed latency and bit-stream checks.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst_n, en;
  always #5 clk = ~clk;

  logic [15:0] a_data;
  logic        a_valid, a_ready, a_sdata, a_sframe, a_start, a_done, a_busy;
  logic [7:0]  b_data;
  logic        b_valid, b_ready, b_sdata, b_sframe, b_start, b_done, b_busy;

  piso_serializer #(.WIDTH(16), .LSB_FIRST(1'b0), .BIT_PERIOD(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready),
    .sdata(a_sdata), .sframe(a_sframe), .sword_start(a_start), .done(a_done), .busy(a_busy)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .BIT_PERIOD(3)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
    .sdata(b_sdata), .sframe(b_sframe), .sword_start(b_start), .done(b_done), .busy(b_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int gap_pct  = 0;

  int cfg_w[2]   = '{16, 8};
  int cfg_bp[2]  = '{1, 3};
  bit cfg_lsb[2] = '{1'b0, 1'b1};

  // Reference model: current word, cycle index within it, one pending word.
  bit          m_active[2];
  bit          m_pend[2];
  int          m_c[2];
  logic [63:0] m_cur[2];
  logic [63:0] m_pw[2];

  logic [63:0] txq0[$];
  logic [63:0] txq1[$];
  int          a_xfers[$], b_xfers[$], a_starts[$];
  int          a_done_cyc, b_done_cyc, a_done_n;
  logic [63:0] a_bits, b_bits;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cycle, obs, exp);
    end
  endtask

  function automatic logic exp_sdata(input int id);
    int b, idx;
    if (!m_active[id]) return 1'b0;
    b   = m_c[id] / cfg_bp[id];
    idx = cfg_lsb[id] ? b : cfg_w[id] - 1 - b;
    return m_cur[id][idx];
  endfunction

  function automatic logic exp_start(input int id);
    return en && m_active[id] && (m_c[id] == 0);
  endfunction

  function automatic logic exp_done(input int id);
    return en && m_active[id] && (m_c[id] == cfg_w[id] * cfg_bp[id] - 1);
  endfunction

  function automatic logic exp_ready(input int id);
    return en && rst_n && !m_pend[id];
  endfunction

  function automatic bit all_idle();
    return txq0.size() == 0 && txq1.size() == 0 && !m_active[0] && !m_active[1]
           && !m_pend[0] && !m_pend[1];
  endfunction

  task automatic model_step(input int id, input logic v, input logic [63:0] d, output bit xfer);
    bit we;
    xfer = 1'b0;
    if (!rst_n) begin
      m_active[id] = 1'b0;
      m_pend[id]   = 1'b0;
      m_c[id]      = 0;
    end else if (en) begin
      xfer = v && !m_pend[id];
      we   = m_active[id] && (m_c[id] == cfg_w[id] * cfg_bp[id] - 1);
      if (!m_active[id] || we) begin
        if (m_pend[id]) begin
          m_cur[id] = m_pw[id]; m_pend[id] = 1'b0; m_c[id] = 0; m_active[id] = 1'b1;
        end else if (xfer) begin
          m_cur[id] = d; m_c[id] = 0; m_active[id] = 1'b1;
        end else begin
          m_active[id] = 1'b0;
        end
      end else begin
        m_c[id]++;
        if (xfer) begin
          m_pw[id] = d; m_pend[id] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("a_sdata", a_sdata, exp_sdata(0));
    chk("a_sframe", a_sframe, m_active[0]);
    chk("a_sword_start", a_start, exp_start(0));
    chk("a_done", a_done, exp_done(0));
    chk("a_busy", a_busy, m_active[0] | m_pend[0]);
    chk("a_s_ready", a_ready, exp_ready(0));
    chk("b_sdata", b_sdata, exp_sdata(1));
    chk("b_sframe", b_sframe, m_active[1]);
    chk("b_sword_start", b_start, exp_start(1));
    chk("b_done", b_done, exp_done(1));
    chk("b_busy", b_busy, m_active[1] | m_pend[1]);
    chk("b_s_ready", b_ready, exp_ready(1));
  endtask

  task automatic cyc();
    bit ta, tb;
    @(negedge clk);
    check_outputs();
    if (a_sframe) a_bits = {a_bits[62:0], a_sdata};
    if (b_sframe) b_bits = {b_bits[62:0], b_sdata};
    if (a_done) begin a_done_cyc = cycle; a_done_n++; end
    if (b_done) b_done_cyc = cycle;
    if (a_start) a_starts.push_back(cycle);
    @(posedge clk);
    model_step(0, a_valid, {48'd0, a_data}, ta);
    model_step(1, b_valid, {56'd0, b_data}, tb);
    if (ta) a_xfers.push_back(cycle);
    if (tb) b_xfers.push_back(cycle);
    cycle++;
    #1;
    if (ta) void'(txq0.pop_front());
    if (tb) void'(txq1.pop_front());
    if (!a_valid || ta) begin
      if (txq0.size() > 0 && $urandom_range(99) >= gap_pct) begin
        a_valid = 1'b1; a_data = txq0[0][15:0];
      end else a_valid = 1'b0;
    end
    if (!b_valid || tb) begin
      if (txq1.size() > 0 && $urandom_range(99) >= gap_pct) begin
        b_valid = 1'b1; b_data = txq1[0][7:0];
      end else b_valid = 1'b0;
    end
  endtask

  task automatic run_idle(input int max_cyc, input string tag);
    int i = 0;
    while (!all_idle() && i < max_cyc) begin
      cyc();
      i++;
    end
    chk(tag, all_idle(), 1'b1);
  endtask

  task automatic clear_logs();
    a_xfers.delete(); b_xfers.delete(); a_starts.delete();
    a_bits = '0; b_bits = '0;
  endtask

  initial begin
    int i;
    rst_n = 1'b0; en = 1'b1;
    a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0;
    repeat (2) @(posedge clk);
    #1;
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();

    // Single words on both configurations
    clear_logs();
    txq0.push_back(64'hA5C3);
    txq1.push_back(64'h81);
    run_idle(60, "single_timeout");
    repeat (2) cyc();
    chk("a_done_latency", 64'(a_done_cyc - a_xfers[0]), 64'd16);
    chk("b_done_latency", 64'(b_done_cyc - b_xfers[0]), 64'd24);
    chk("a_bitstream", a_bits[15:0], 64'hA5C3);
    chk("b_bitstream", b_bits[23:0], 64'hE00007);

    // Back-to-back words with valid held
    clear_logs();
    txq0.push_back(64'h1234); txq0.push_back(64'h5678); txq0.push_back(64'h9ABC);
    run_idle(80, "b2b_timeout");
    repeat (2) cyc();
    chk("b2b_bitstream", a_bits[47:0], 64'h123456789ABC);
    chk("b2b_start_count", a_starts.size(), 3);
    if (a_starts.size() >= 3 && a_xfers.size() >= 1) begin
      chk("b2b_first_start", 64'(a_starts[0] - a_xfers[0]), 64'd1);
      chk("b2b_start_gap1", 64'(a_starts[1] - a_starts[0]), 64'd16);
      chk("b2b_start_gap2", 64'(a_starts[2] - a_starts[1]), 64'd16);
    end

    // en stall mid-word
    clear_logs();
    txq0.push_back(64'hFFFF);
    i = 0;
    while (!m_active[0] && i < 10) begin cyc(); i++; end
    repeat (4) cyc();
    en = 1'b0;
    repeat (5) cyc();
    en = 1'b1;
    run_idle(40, "stall_timeout");
    repeat (2) cyc();
    chk("stall_done_latency", 64'(a_done_cyc - a_xfers[0]), 64'd21);
    chk("stall_bitstream", a_bits[20:0], 64'h1FFFFF);

    // Reset mid-word with a pending word
    clear_logs();
    txq0.push_back(64'hF0F0); txq0.push_back(64'h0F0F);
    i = 0;
    while (!(m_active[0] && m_c[0] == 7) && i < 20) begin cyc(); i++; end
    a_done_n = 0;
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_no_done", a_done_n, 0);
    chk("rst_ready_after", a_ready, 1'b1);
    chk("rst_busy_after", a_busy, 1'b0);
    repeat (3) cyc();

    // Transfer in word-end cycle with pending empty bypasses straight in
    clear_logs();
    txq0.push_back(64'hC001);
    i = 0;
    while (!(m_active[0] && m_c[0] == 14) && i < 20) begin cyc(); i++; end
    txq0.push_back(64'h3EE7);
    run_idle(40, "bypass_timeout");
    repeat (2) cyc();
    chk("bypass_xfer_count", a_xfers.size(), 2);
    if (a_xfers.size() >= 2 && a_starts.size() >= 2) begin
      chk("bypass_xfer_gap", 64'(a_xfers[1] - a_xfers[0]), 64'd16);
      chk("bypass_start_gap", 64'(a_starts[1] - a_starts[0]), 64'd16);
    end
    chk("bypass_bitstream", a_bits[31:0], 64'hC0013EE7);

    // Randomized words, valid gaps and en drops
    gap_pct = 30;
    for (int k = 0; k < 20; k++) begin
      txq0.push_back({48'd0, 16'($urandom)});
      txq1.push_back({56'd0, 8'($urandom)});
    end
    i = 0;
    while (!all_idle() && i < 3000) begin
      en = ($urandom_range(99) >= 10);
      cyc();
      i++;
    end
    en = 1'b1;
    run_idle(100, "random_timeout");
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
